// File: rtl/blk_mem_pkg.sv
// Shared constants for the 32-bit byte-writable dual-port block memory.
package blk_mem_pkg;
    localparam int DATA_W     = 32;
    localparam int BYTES      = 4;
    localparam int BYTE_W     = DATA_W / BYTES;
    localparam int ADDR_W_DEF = 14;
endpackage

// File: rtl/blk_mem_lane.sv
// One 8-bit true dual-port READ_FIRST RAM lane; port A wins a same-address write collision.
module blk_mem_lane
    import blk_mem_pkg::*;
#(
    parameter int    ADDR_W    = ADDR_W_DEF,
    parameter int    DEPTH     = 2**ADDR_W,
    parameter int    LANE      = 0,
    parameter string INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [BYTE_W-1:0] dina,
    output logic [BYTE_W-1:0] douta,
    input  logic              enb,
    input  logic              web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [BYTE_W-1:0] dinb,
    output logic [BYTE_W-1:0] doutb
);
    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] douta_q, doutb_q;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic              a_in, b_in;

    assign a_in  = ({1'b0, addra} < DEPTH_LIM);
    assign b_in  = ({1'b0, addrb} < DEPTH_LIM);
    assign idx_a = addra[IDX_W-1:0];
    assign idx_b = addrb[IDX_W-1:0];

    // Power-up image: all words start at zero.
    initial begin : init_mem
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // B is written before A so that A's data survives a same-address collision.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (enb && web && b_in) mem[idx_b] <= dinb;
            if (ena && wea && a_in) mem[idx_a] <= dina;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            douta_q <= '0;
            doutb_q <= '0;
        end else begin
            if (ena) douta_q <= a_in ? mem[idx_a] : '0;
            if (enb) doutb_q <= b_in ? mem[idx_b] : '0;
        end
    end

    assign douta = douta_q;
    assign doutb = doutb_q;
endmodule

// File: rtl/blk_mem_gen.sv
// 32-bit true dual-port byte-writable block memory built from four 8-bit lanes.
module blk_mem_gen
    import blk_mem_pkg::*;
#(
    parameter int    ADDR_W    = ADDR_W_DEF,
    parameter int    DEPTH     = 2**ADDR_W,
    parameter string INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ena,
    input  logic [BYTES-1:0]  wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    input  logic              enb,
    input  logic [BYTES-1:0]  web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dinb,
    output logic [DATA_W-1:0] doutb
);
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        blk_mem_lane #(
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .LANE     (gi),
            .INIT_FILE(INIT_FILE)
        ) u_lane (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .ena   (ena),
            .wea   (wea[gi]),
            .addra (addra),
            .dina  (dina[gi*BYTE_W +: BYTE_W]),
            .douta (douta[gi*BYTE_W +: BYTE_W]),
            .enb   (enb),
            .web   (web[gi]),
            .addrb (addrb),
            .dinb  (dinb[gi*BYTE_W +: BYTE_W]),
            .doutb (doutb[gi*BYTE_W +: BYTE_W])
        );
    end
endmodule

// File: tb/tb_blk_mem_gen.sv
// Scoreboard bench for blk_mem_gen: directed scenarios plus random dual-port traffic.
module tb_blk_mem_gen;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 12000;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              ena = 1'b0, enb = 1'b0;
    logic [3:0]        wea = '0, web = '0;
    logic [ADDR_W-1:0] addra = '0, addrb = '0;
    logic [31:0]       dina = '0, dinb = '0;
    logic [31:0]       douta, doutb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [int];
    logic [31:0] qa [$];
    logic [31:0] qb [$];

    blk_mem_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input int a);
        if (a >= DEPTH) return 32'h0;
        return model.exists(a) ? model[a] : 32'h0;
    endfunction

    // Apply one port write to the model; bytes merge per enable.
    function automatic void wr(input int a, input logic [3:0] we, input logic [31:0] d);
        logic [31:0] w;
        if (a >= DEPTH) return;
        w = rd(a);
        for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = d[8*i +: 8];
        model[a] = w;
    endfunction

    // Drive one request cycle; the model reads old data, then B writes, then A (A wins).
    task automatic cycle(input logic ea, input logic [3:0] wa, input int aa, input logic [31:0] da,
                         input logic eb, input logic [3:0] wb, input int ab, input logic [31:0] db);
        @(negedge clk);
        ena = ea; wea = wa; addra = ADDR_W'(aa); dina = da;
        enb = eb; web = wb; addrb = ADDR_W'(ab); dinb = db;
        $display("cyc t=%0t A(en=%0b we=%h a=%0d d=%h) B(en=%0b we=%h a=%0d d=%h)",
                 $time, ea, wa, aa, da, eb, wb, ab, db);
        if (rst_ni) begin
            if (ea) qa.push_back(rd(aa));
            if (eb) qb.push_back(rd(ab));
            if (eb) wr(ab, wb, db);
            if (ea) wr(aa, wa, da);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 0, 32'h0, 1'b0, 4'h0, 0, 32'h0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops an expected word whenever a port was enabled on the edge, else expects hold.
    logic [31:0] last_a = '0, last_b = '0;
    always @(posedge clk) begin
        logic sa, sb, rs;
        rs = rst_ni;
        sa = rst_ni && ena;
        sb = rst_ni && enb;
        #1;
        if (!rs) begin
            last_a = '0;
            last_b = '0;
        end
        if (sa) begin
            if (qa.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL qa_empty: got no expected entry, required one");
            end else last_a = qa.pop_front();
        end
        if (sb) begin
            if (qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL qb_empty: got no expected entry, required one");
            end else last_b = qb.pop_front();
        end
        chk("mon_douta", douta, last_a);
        chk("mon_doutb", doutb, last_b);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset_douta", douta, 32'h0);
        chk("reset_doutb", doutb, 32'h0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // Basic write then read on A
        cycle(1, 4'hF, 5, 32'hDEADBEEF, 0, 4'h0, 0, 32'h0);
        cycle(1, 4'h0, 5, 32'h0,        0, 4'h0, 0, 32'h0);
        after_edge();
        chk("basic_rd_a5", douta, 32'hDEADBEEF);

        // Byte enables, read back through B
        cycle(1, 4'b0101, 5, 32'h11223344, 0, 4'h0, 0, 32'h0);
        cycle(0, 4'h0,    0, 32'h0,        1, 4'h0, 5, 32'h0);
        after_edge();
        chk("byte_en_b5", doutb, 32'hDE22BE44);

        // READ_FIRST on a write
        cycle(1, 4'hF, 9, 32'hA5A5A5A5, 0, 4'h0, 0, 32'h0);
        cycle(1, 4'hF, 9, 32'h0,        0, 4'h0, 0, 32'h0);
        after_edge();
        chk("read_first_old", douta, 32'hA5A5A5A5);
        cycle(1, 4'h0, 9, 32'h0, 0, 4'h0, 0, 32'h0);
        after_edge();
        chk("read_first_new", douta, 32'h0);

        // Same-address collision with overlapping byte enables
        cycle(1, 4'h3, 3, 32'hAAAAAAAA, 1, 4'h6, 3, 32'hBBBBBBBB);
        after_edge();
        chk("collide_b_old", doutb, 32'h0);
        cycle(1, 4'h0, 3, 32'h0, 0, 4'h0, 0, 32'h0);
        after_edge();
        chk("collide_rd", douta, 32'h00BBAAAA);

        // Enable hold: disabled A ignores address and write enables
        cycle(1, 4'hF, 20, 32'h12345678, 0, 4'h0, 0, 32'h0);
        cycle(1, 4'h0, 20, 32'h0,        0, 4'h0, 0, 32'h0);
        after_edge();
        chk("hold_setup", douta, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'($urandom), 20 + i, $urandom, 0, 4'h0, 0, 32'h0);
            after_edge();
            chk("hold_douta", douta, 32'h12345678);
        end
        cycle(0, 4'h0, 0, 32'h0, 1, 4'h0, 21, 32'h0);
        after_edge();
        chk("hold_mem21", doutb, 32'h0);

        // Out-of-range addresses: writes ignored, reads return zero
        cycle(1, 4'hF, 12000, 32'hCAFEF00D, 1, 4'hF, 16383, 32'h87654321);
        cycle(1, 4'h0, 12000, 32'h0,        1, 4'h0, 16383, 32'h0);
        after_edge();
        chk("oob_a", douta, 32'h0);
        chk("oob_b", doutb, 32'h0);
        cycle(1, 4'h0, 11999, 32'h0, 0, 4'h0, 0, 32'h0);
        after_edge();
        chk("last_word", douta, 32'h0);

        // Random traffic, mostly on a small address window to provoke collisions
        for (int n = 0; n < 300; n++) begin
            int a, b;
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH - 2, 16383) : $urandom_range(0, 15);
            b = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH - 2, 16383) : $urandom_range(0, 15);
            cycle($urandom_range(0, 3) != 0, 4'($urandom), a, $urandom,
                  $urandom_range(0, 3) != 0, 4'($urandom), b, $urandom);
        end

        // Asynchronous reset mid-cycle; memory must survive it
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_a", douta, 32'h0);
        chk("async_rst_b", doutb, 32'h0);
        cycle(1, 4'hF, 5, 32'hFFFFFFFF, 1, 4'hF, 5, 32'hEEEEEEEE);
        cycle(1, 4'hF, 5, 32'hFFFFFFFF, 1, 4'hF, 5, 32'hEEEEEEEE);
        @(negedge clk);
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
        rst_ni = 1'b1;
        cycle(1, 4'h0, 5, 32'h0, 1, 4'h0, 9, 32'h0);
        after_edge();
        chk("post_rst_a5", douta, rd(5));
        chk("post_rst_b9", doutb, rd(9));

        idle();
        idle();
        after_edge();
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
